// File: rtl/lru_victim_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lru_victim_ctrl : per-set age counters with a sequential min-age victim
//                   scan offered over a valid/ready handshake.   Rev 1.0
// ---------------------------------------------------------------------------
module lru_victim_ctrl #(
  parameter int WAYS  = 4,
  parameter int N     = 3,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_way,
  input  logic             victim_req,
  output logic             victim_valid,
  input  logic             victim_ready,
  output logic [IDX_W-1:0] victim_way,
  output logic             busy,
  output logic [WAYS-1:0]  lru_vec
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_OFFER = 2'd2
  } state_t;

  localparam logic [N-1:0]     MAX_AGE  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WAYS - 1);

  state_t           state;
  logic [N-1:0]     age [WAYS];
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] best_idx;
  logic [N-1:0]     best_age;

  logic             way_ok;
  logic             accept;
  logic             upd_en;
  logic [IDX_W-1:0] upd_way;
  logic             cand_better;
  logic [IDX_W-1:0] cand_idx;
  logic [N-1:0]     cand_age;

  // Out-of-range touch indices only exist when WAYS is not a power of two.
  generate
    if (WAYS == (1 << IDX_W)) begin : g_pow2
      assign way_ok = 1'b1;
    end else begin : g_npow2
      assign way_ok = (touch_way <= LAST_IDX);
    end
  endgenerate

  // The accept touch takes priority; a simultaneous external touch is dropped.
  assign accept  = (state == S_OFFER) && victim_ready;
  assign upd_en  = accept || (touch_en && way_ok);
  assign upd_way = accept ? victim_way : touch_way;

  // Strict compare keeps the earliest index on ties.
  assign cand_better = (age[scan_idx] < best_age);
  assign cand_idx    = cand_better ? scan_idx : best_idx;
  assign cand_age    = cand_better ? age[scan_idx] : best_age;

  generate
    for (genvar i = 0; i < WAYS; i++) begin : g_lru
      assign lru_vec[i] = (age[i] == '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      victim_valid <= 1'b0;
      victim_way   <= '0;
      busy         <= 1'b0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best_age     <= '1;
      for (int j = 0; j < WAYS; j++) begin
        age[j] <= '0;
      end
    end else begin
      if (upd_en) begin
        for (int j = 0; j < WAYS; j++) begin
          if (IDX_W'(j) == upd_way) begin
            age[j] <= MAX_AGE;
          end else if (age[j] != '0) begin
            age[j] <= age[j] - 1'b1;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (victim_req) begin
            state    <= S_SCAN;
            busy     <= 1'b1;
            scan_idx <= '0;
            best_age <= '1;
            best_idx <= '0;
          end
        end
        S_SCAN: begin
          best_age <= cand_age;
          best_idx <= cand_idx;
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == LAST_IDX) begin
            state        <= S_OFFER;
            victim_valid <= 1'b1;
            victim_way   <= cand_idx;
          end
        end
        S_OFFER: begin
          if (victim_ready) begin
            state        <= S_IDLE;
            victim_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          victim_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lru_victim_ctrl.sv
`default_nettype none
// tb_lru_victim_ctrl : directed and random checks of lru_victim_ctrl against a
// transaction-level model of the age counters and victim choice.
module tb_lru_victim_ctrl;
  localparam int WAYS = 4;
  localparam int MAXA = 7;

  logic       clk = 1'b0;
  logic       rst, touch_en, victim_req, victim_ready;
  logic [1:0] touch_way;
  logic       victim_valid, busy;
  logic [1:0] victim_way;
  logic [3:0] lru_vec;

  logic       rst3, ten3, req3, rdy3;
  logic [1:0] tw3;
  logic       vv3, busy3;
  logic [1:0] vw3;
  logic [2:0] lru3;

  always #5 clk = ~clk;

  lru_victim_ctrl #(.WAYS(4), .N(3)) u_dut (
    .clk(clk), .rst(rst), .touch_en(touch_en), .touch_way(touch_way),
    .victim_req(victim_req), .victim_valid(victim_valid),
    .victim_ready(victim_ready), .victim_way(victim_way),
    .busy(busy), .lru_vec(lru_vec)
  );

  lru_victim_ctrl #(.WAYS(3), .N(3)) u_dut3 (
    .clk(clk), .rst(rst3), .touch_en(ten3), .touch_way(tw3),
    .victim_req(req3), .victim_valid(vv3),
    .victim_ready(rdy3), .victim_way(vw3),
    .busy(busy3), .lru_vec(lru3)
  );

  int errors = 0;
  int checks = 0;

  // Model: ages as integers, phase 0=idle 1=scanning 2=offering.
  int m_age [WAYS];
  int seen  [WAYS];
  int m_phase, m_k, m_vway;

  function automatic void m_touch(input int w);
    if (w >= WAYS) return;
    for (int j = 0; j < WAYS; j++)
      m_age[j] = (j == w) ? MAXA : ((m_age[j] > 0) ? m_age[j] - 1 : 0);
  endfunction

  function automatic logic [3:0] m_lru();
    logic [3:0] r;
    for (int j = 0; j < WAYS; j++) r[j] = (m_age[j] == 0);
    return r;
  endfunction

  // Victim = first way holding the smallest age observed during the scan.
  function automatic int m_pick();
    int mn = seen[0];
    int id = 0;
    for (int j = 1; j < WAYS; j++)
      if (seen[j] < mn) begin mn = seen[j]; id = j; end
    return id;
  endfunction

  task automatic cycle(input logic t_en, input int t_way, input logic req, input logic rdy);
    bit acc;
    touch_en = t_en; touch_way = t_way[1:0]; victim_req = req; victim_ready = rdy;
    acc = (m_phase == 2) && rdy;
    case (m_phase)
      0: if (req) begin m_phase = 1; m_k = 0; end
      1: begin
        seen[m_k] = m_age[m_k];
        m_k++;
        if (m_k == WAYS) begin m_phase = 2; m_vway = m_pick(); end
      end
      default: if (rdy) m_phase = 0;
    endcase
    if (acc) m_touch(m_vway);
    else if (t_en) m_touch(t_way);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic req);
    rst = 1'b1; touch_en = 1'b0; touch_way = 2'd0; victim_req = req; victim_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; victim_req = 1'b0;
    for (int j = 0; j < WAYS; j++) m_age[j] = 0;
    m_phase = 0; m_k = 0; m_vway = 0;
  endtask

  task automatic drive3(input logic te, input logic [1:0] tw, input logic rq, input logic rd);
    ten3 = te; tw3 = tw; req3 = rq; rdy3 = rd;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks += 4;
    if (victim_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", victim_valid); end
    if (victim_way !== 2'd0) begin errors++; $display("FAIL reset_way: got %0d expected 0", victim_way); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    if (lru_vec !== 4'b1111) begin errors++; $display("FAIL reset_lru: got %b expected 1111", lru_vec); end
  endtask

  task automatic test_first_victim();
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      checks += 2;
      if (victim_valid !== 1'b0) begin errors++; $display("FAIL latency_valid_early: cycle %0d got %0b expected 0", i, victim_valid); end
      if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy: cycle %0d got %0b expected 1", i, busy); end
    end
    cycle(0, 0, 0, 0);
    checks += 3;
    if (victim_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %0b expected 1", victim_valid); end
    if (victim_way !== 2'd0) begin errors++; $display("FAIL first_victim: got %0d expected 0", victim_way); end
    if (lru_vec !== 4'b1111) begin errors++; $display("FAIL first_lru: got %b expected 1111", lru_vec); end
    cycle(0, 0, 0, 1);
    checks += 2;
    if (victim_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL first_accept: got valid=%0b busy=%0b expected 0 0", victim_valid, busy); end
    if (lru_vec !== 4'b1110) begin errors++; $display("FAIL first_accept_lru: got %b expected 1110", lru_vec); end
  endtask

  task automatic request_and_wait();
    cycle(0, 0, 1, 0);
    for (int i = 0; i < WAYS; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic test_touch_seq();
    do_reset(1'b0);
    for (int w = 0; w < WAYS; w++) cycle(1, w, 0, 0);
    checks++;
    if (lru_vec !== 4'b0000) begin errors++; $display("FAIL seq_lru: got %b expected 0000", lru_vec); end
    request_and_wait();
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin errors++; $display("FAIL seq_victim: got valid=%0b way=%0d expected 1 0", victim_valid, victim_way); end
    cycle(0, 0, 0, 1);
    checks++;
    if (lru_vec !== 4'b0000) begin errors++; $display("FAIL seq_accept_lru: got %b expected 0000", lru_vec); end
    request_and_wait();
    checks++;
    if (victim_way !== 2'd1) begin errors++; $display("FAIL seq_second_victim: got %0d expected 1", victim_way); end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_saturate();
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) cycle(1, 3, 0, 0);
    checks++;
    if (lru_vec !== 4'b0111) begin errors++; $display("FAIL sat_lru: got %b expected 0111", lru_vec); end
    request_and_wait();
    checks++;
    if (victim_way !== 2'd0) begin errors++; $display("FAIL sat_tie_victim: got %0d expected 0", victim_way); end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_hold();
    do_reset(1'b0);
    cycle(1, 0, 0, 0);
    cycle(1, 2, 0, 0);
    request_and_wait();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== 2'd1) begin errors++; $display("FAIL hold: cycle %0d got valid=%0b way=%0d expected 1 1", i, victim_valid, victim_way); end
    end
    cycle(0, 0, 0, 1);
    checks += 2;
    if (victim_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_accept: got valid=%0b busy=%0b expected 0 0", victim_valid, busy); end
    if (lru_vec !== 4'b1000) begin errors++; $display("FAIL hold_accept_lru: got %b expected 1000", lru_vec); end
  endtask

  task automatic test_reset_mid_scan();
    do_reset(1'b0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    do_reset(1'b1);
    checks += 2;
    if (busy !== 1'b0 || victim_valid !== 1'b0) begin errors++; $display("FAIL midscan_reset: got busy=%0b valid=%0b expected 0 0", busy, victim_valid); end
    if (lru_vec !== 4'b1111) begin errors++; $display("FAIL midscan_lru: got %b expected 1111", lru_vec); end
    cycle(0, 0, 0, 0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midscan_req_ignored: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_ways3();
    rst3 = 1'b1;
    drive3(0, 2'd0, 0, 0);
    rst3 = 1'b0;
    drive3(1, 2'd3, 0, 0);
    checks++;
    if (lru3 !== 3'b111) begin errors++; $display("FAIL w3_oob_touch: got %b expected 111", lru3); end
    drive3(1, 2'd1, 0, 0);
    drive3(1, 2'd3, 0, 0);
    checks++;
    if (lru3 !== 3'b101) begin errors++; $display("FAIL w3_oob_keep: got %b expected 101", lru3); end
    drive3(0, 2'd0, 1, 0);
    for (int i = 0; i < 2; i++) drive3(0, 2'd0, 1, 0);
    checks++;
    if (vv3 !== 1'b0 || busy3 !== 1'b1) begin errors++; $display("FAIL w3_scan: got valid=%0b busy=%0b expected 0 1", vv3, busy3); end
    drive3(0, 2'd0, 1, 0);
    checks++;
    if (vv3 !== 1'b1 || vw3 !== 2'd0) begin errors++; $display("FAIL w3_offer: got valid=%0b way=%0d expected 1 0", vv3, vw3); end
    for (int i = 0; i < 3; i++) drive3(0, 2'd0, 1, 0);
    drive3(0, 2'd0, 1, 1);
    checks += 2;
    if (vv3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL w3_accept: got valid=%0b busy=%0b expected 0 0", vv3, busy3); end
    if (lru3 !== 3'b100) begin errors++; $display("FAIL w3_accept_lru: got %b expected 100", lru3); end
    for (int i = 0; i < 3; i++) begin
      drive3(0, 2'd0, 0, 0);
      checks++;
      if (busy3 !== 1'b0 || vv3 !== 1'b0) begin errors++; $display("FAIL w3_no_requeue: cycle %0d got busy=%0b valid=%0b expected 0 0", i, busy3, vv3); end
    end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4));
      checks += 4;
      if (victim_valid !== (m_phase == 2)) begin errors++; $display("FAIL rnd_valid: cycle %0d got %0b expected %0b", i, victim_valid, (m_phase == 2)); end
      if (busy !== (m_phase != 0)) begin errors++; $display("FAIL rnd_busy: cycle %0d got %0b expected %0b", i, busy, (m_phase != 0)); end
      if (lru_vec !== m_lru()) begin errors++; $display("FAIL rnd_lru: cycle %0d got %b expected %b", i, lru_vec, m_lru()); end
      if (victim_way !== 2'(m_vway)) begin errors++; $display("FAIL rnd_way: cycle %0d got %0d expected %0d", i, victim_way, m_vway); end
    end
  endtask

  initial begin
    rst = 1'b1; touch_en = 1'b0; touch_way = 2'd0; victim_req = 1'b0; victim_ready = 1'b0;
    rst3 = 1'b1; ten3 = 1'b0; tw3 = 2'd0; req3 = 1'b0; rdy3 = 1'b0;
    for (int j = 0; j < WAYS; j++) begin m_age[j] = 0; seen[j] = 0; end
    m_phase = 0; m_k = 0; m_vway = 0;
    test_reset();
    test_first_victim();
    test_touch_seq();
    test_saturate();
    test_hold();
    test_reset_mid_scan();
    test_ways3();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
